// File: rtl/counter_timer_rtl.sv
// Parametrised down-counting timer: load/run/stop with one-shot or periodic reload.
// Optional prescaler enabled by defining COUNTER_TIMER_PRESCALE_EN.
module counter_timer_rtl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             periodic,
    input  logic             en,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             expire,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
        $error("counter_timer_rtl: WIDTH or PRESCALE out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_expire;
    logic             w_next_expire;
    logic             w_step;

`ifdef COUNTER_TIMER_PRESCALE_EN
    localparam int unsigned    PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    assign w_step = (r_state == RUN) && en && (r_pre == PRE_MAX);

    // Cleared on any path back to IDLE so every run starts a full prescale period.
    always_ff @(posedge clk) begin
        if (rst || load || stop || (w_next_state == IDLE)) begin
            r_pre <= '0;
        end else if ((r_state == RUN) && en) begin
            r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
        end
    end
`else
    assign w_step = (r_state == RUN) && en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_expire <= w_next_expire;
            if (load) begin
                r_reload <= in;
                r_mode   <= periodic;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_expire = 1'b0;
        if (load) begin
            w_next_count = in;
            w_next_state = (in != '0) ? RUN : IDLE;
        end else if (stop) begin
            w_next_count = '0;
            w_next_state = IDLE;
        end else if (w_step) begin
            if (r_count == ONE) begin
                w_next_expire = 1'b1;
                if (r_mode) begin
                    w_next_count = r_reload;
                end else begin
                    w_next_count = '0;
                    w_next_state = IDLE;
                end
            end else begin
                w_next_count = r_count - ONE;
            end
        end
    end

    always_comb begin
        count  = r_count;
        done   = (r_count == '0);
        expire = r_expire;
        busy   = (r_state == RUN);
    end

endmodule
